// File: rtl/modaddsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : modaddsub_serial
// Description : Digit-serial adder/subtractor with optional modular
//               reduction. Computes a+b, a-b, (a+b) mod m or (a-b) mod m
//               over WIDTH bits, DIGIT bits per clock, LSD first. Modular
//               modes run a second correction pass over the pass-1 result.
// Ports       :
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   i_start    operation request, sampled only while idle
//   i_op       00 add, 01 sub, 10 mod add, 11 mod sub (sampled with start)
//   i_a, i_b   operands (sampled with start)
//   i_m        modulus (sampled with start, used when i_op[1]=1)
//   o_result   result, valid from the done cycle until the next start
//   o_carry    add: carry out; sub: borrow; modular: correction applied
//   o_ready_n  0 = idle/accepting, 1 = busy
//   o_done     one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module modaddsub_serial #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_ready_n,
  output logic             o_done
);

  localparam int N    = WIDTH / DIGIT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] c_LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [1:0]       r_op;
  logic [IDXW-1:0]  r_idx;
  logic             r_c;      // running digit carry
  logic             r_c1;     // final carry of pass 1
  logic [WIDTH-1:0] r_t;      // pass-2 candidate (corrected) result
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_ready_n;
  logic             r_done;

  logic             w_pass2;
  logic             w_last;
  logic             w_inv;
  int               w_base;
  logic [DIGIT-1:0] w_x;
  logic [DIGIT-1:0] w_y_raw;
  logic [DIGIT-1:0] w_y;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_res_upd;
  logic [WIDTH-1:0] w_t_upd;
  logic             w_correct;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_PASS1;
      S_PASS1: if (w_last)  w_next = r_op[1] ? S_PASS2 : S_IDLE;
      S_PASS2: if (w_last)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Digit adder. Pass 1 works on a/b; pass 2 works on the pass-1 result and
  // the modulus. Subtraction is a + ~b + 1, the +1 coming from the carry
  // seeded at the start of the pass.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pass2   = (r_state == S_PASS2);
    w_last    = (r_idx == c_LAST);
    w_base    = int'(r_idx) * DIGIT;
    w_x       = w_pass2 ? r_res[w_base +: DIGIT] : r_a[w_base +: DIGIT];
    w_y_raw   = w_pass2 ? r_m[w_base +: DIGIT]   : r_b[w_base +: DIGIT];
    // Mod add subtracts m in pass 2; mod sub adds m back.
    w_inv     = w_pass2 ? ~r_op[0] : r_op[0];
    w_y       = w_inv ? ~w_y_raw : w_y_raw;
    w_sum     = {1'b0, w_x} + {1'b0, w_y} + {{DIGIT{1'b0}}, r_c};
    w_res_upd = r_res;
    w_res_upd[w_base +: DIGIT] = w_sum[DIGIT-1:0];
    w_t_upd   = r_t;
    w_t_upd[w_base +: DIGIT]   = w_sum[DIGIT-1:0];
    // Mod add: reduce when the sum overflowed WIDTH bits or s >= m (no
    // borrow from s - m). Mod sub: add m back when pass 1 borrowed.
    w_correct = r_op[0] ? ~r_c1 : (r_c1 | w_sum[DIGIT]);
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_op      <= '0;
      r_idx     <= '0;
      r_c       <= 1'b0;
      r_c1      <= 1'b0;
      r_t       <= '0;
      r_res     <= '0;
      r_carry   <= 1'b0;
      r_ready_n <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a       <= i_a;
            r_b       <= i_b;
            r_m       <= i_m;
            r_op      <= i_op;
            r_idx     <= '0;
            r_c       <= i_op[0];
            r_c1      <= 1'b0;
            r_t       <= '0;
            r_res     <= '0;
            r_ready_n <= 1'b1;
          end
        end
        S_PASS1: begin
          r_res <= w_res_upd;
          if (w_last) begin
            r_c1  <= w_sum[DIGIT];
            r_idx <= '0;
            if (r_op[1]) begin
              r_c <= ~r_op[0];
            end else begin
              r_carry   <= r_op[0] ? ~w_sum[DIGIT] : w_sum[DIGIT];
              r_done    <= 1'b1;
              r_ready_n <= 1'b0;
            end
          end else begin
            r_idx <= r_idx + IDXW'(1);
            r_c   <= w_sum[DIGIT];
          end
        end
        S_PASS2: begin
          r_t <= w_t_upd;
          if (w_last) begin
            if (w_correct) r_res <= w_t_upd;
            r_carry   <= w_correct;
            r_done    <= 1'b1;
            r_ready_n <= 1'b0;
            r_idx     <= '0;
          end else begin
            r_idx <= r_idx + IDXW'(1);
            r_c   <= w_sum[DIGIT];
          end
        end
        default: begin
          r_ready_n <= 1'b0;
        end
      endcase
    end
  end

  assign o_result  = r_res;
  assign o_carry   = r_carry;
  assign o_ready_n = r_ready_n;
  assign o_done    = r_done;

endmodule
`default_nettype wire

// File: doc/modaddsub_serial.md
# modaddsub_serial

Parametrised digit-serial adder/subtractor with optional modular reduction, the successor to the fixed 64-bit byte-serial add/sub units in the RSA datapath. It computes a+b, a-b, (a+b) mod m or (a-b) mod m over WIDTH bits, DIGIT bits per clock. Modular modes use a second correction pass. It feeds the modular multiply/exponentiate sequencer through a start / ready_n / done handshake.

## Interface
- WIDTH, 64, operand/result width in bits; must be a positive multiple of DIGIT.
- DIGIT, 8, bits processed per cycle; N = WIDTH/DIGIT digits per pass.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- start  in  1  request; sampled only when idle (ready_n=0).
- op  in  2  mode: 00 add, 01 sub, 10 mod add, 11 mod sub; sampled with start.
- a, b  in  WIDTH  operands; sampled with start.
- m  in  WIDTH  modulus; sampled with start; used only when op[1]=1.
- result  out  WIDTH  result; valid from the done cycle, held until the next accepted start.
- carry  out  1  add: carry out; sub: borrow (1 iff a<b); modular modes: 1 iff the correction was applied.
- ready_n  out  1  0 = idle/accepting, 1 = busy.
- done  out  1  one-cycle pulse, result/carry valid.

## Operation
- States: IDLE, PASS1, PASS2. No separate DONE state; done is registered alongside the final digit.
- IDLE with start=1: latch a, b, m, op. Clear the digit index, carry/borrow and temp register; clear result. ready_n<=1, go to PASS1.
- IDLE with start=0: hold all outputs.
- PASS1, digit k=0..N-1, LSD first:
  - Add-type ops (00, 10): s_k = a_k + b_k + c.
  - Sub-type ops (01, 11): s_k = a_k + ~b_k + c, with c initialised to 1 (two's complement).
  - s_k goes to result digit k; c holds the DIGIT+1 bit carry.
  - After digit N-1, c1 = final carry. Sub-type ops record borrow1 = ~c1.
- End of PASS1, op[1]=0: carry <= c1 (add) or borrow1 (sub). done<=1, ready_n<=0, go to IDLE.
- End of PASS1, op[1]=1: reset the digit index and c, go to PASS2.
  - Mod add: PASS2 computes t = s - m digit-serially (c initialised to 1, ~m).
  - Mod sub: PASS2 computes t = d + m (c initialised to 0).
- End of PASS2:
  - Mod add: correct = c1 | c2, i.e. s >= m including WIDTH-bit overflow.
  - Mod sub: correct = borrow1.
  - If correct, result <= t; otherwise result keeps the pass-1 value. carry <= correct, done<=1, ready_n<=0, go to IDLE.
- Preconditions for modular modes: a<m, b<m, m>0. The block does not check them. Out-of-range inputs still produce exactly the select formula above.
- start while busy is ignored; operand inputs may change freely while busy.

## Timing
- Start accepted at edge E0 (the rising edge at which start=1 is sampled in IDLE).
- Plain ops: digit k written at edge E0+1+k. Final digit at E0+N, where done=1, ready_n=0 and result/carry are valid. Latency N cycles.
- Modular ops: PASS2 digits at edges E0+N+1 .. E0+2N; done at E0+2N. Latency 2N cycles.
- done is high for exactly one cycle. A start asserted in the done cycle is accepted at the next edge (back-to-back, zero bubble).
- Reset values: result=0, carry=0, ready_n=0, done=0, state IDLE.
- rst wins over everything, including mid-operation: the operation is aborted, done is not pulsed, and outputs return to reset values at the next edge.
- rst and start together: reset wins; start is dropped.

## Test plan
- Carry wrap (WIDTH=64, DIGIT=8), op=00, a=FFFF_FFFF_FFFF_FFFF, b=1 -> result=0, carry=1, done exactly 8 cycles after the start edge, ready_n=1 in between.
- Sub borrow, op=01, a=5, b=7 -> result=FFFF_FFFF_FFFF_FFFE, carry=1; then a=7, b=5 -> result=2, carry=0.
- Mod add with overflow, op=10, m=FFFF_FFFF_FFFF_FFC5, a=b=m-1 -> result=FFFF_FFFF_FFFF_FFC3, carry=1, latency 16. Also a=1, b=2 -> result=3, carry=0.
- Mod sub, op=11, m=0x17: a=3, b=5 -> result=0x15, carry=1; a=5, b=3 -> result=2, carry=0.
- Control: start pulsed at cycles 2 and 5 while busy is ignored (single done). rst at cycle 4 of a mod add -> next cycle result=0, ready_n=0, no done pulse. rst+start together -> no operation.
- WIDTH=32, DIGIT=4, op=00, a=b=8000_0000 -> result=0, carry=1, done after 8 cycles. A second start in the done cycle (op=01, a=1, b=1) -> result=0, carry=0, done 8 cycles later.
